// File: rtl/gray_code_counter.sv
// Registered up/down binary counter with Gray-coded twin output,
// load, wrap/saturate boundary control and terminal-count pulse.
module gray_code_counter #(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] binary,
  output logic [WIDTH-1:0] gray,
  output logic             tc
);

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] next_bin;
  logic [WIDTH-1:0] next_gray;
  logic             boundary;
  logic             next_tc;

  always_comb begin
    load_bin = '0;
    load_bin[WIDTH-1] = load_gray[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) begin
      load_bin[i] = load_bin[i+1] ^ load_gray[i];
    end
  end

  assign boundary = up ? (&binary) : ~(|binary);
  assign step = up ? binary + WIDTH'(1) : binary - WIDTH'(1);

  always_comb begin
    next_bin = binary;
    next_tc  = 1'b0;
    if (load) begin
      next_bin = load_bin;
    end else if (en) begin
      next_tc = boundary;
      if (!boundary || WRAP) next_bin = step;
    end
  end

  // Gray is derived from the next count so both outputs move on one edge
  assign next_gray = next_bin ^ (next_bin >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      binary <= '0;
      gray   <= '0;
      tc     <= 1'b0;
    end else begin
      binary <= next_bin;
      gray   <= next_gray;
      tc     <= next_tc;
    end
  end

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed bench for gray_code_counter: wrap-mode and
// saturate-mode instances driven from the same stimulus.
module tb_gray_code_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_gray;
  logic [3:0] w_bin, w_gray, s_bin, s_gray;
  logic       w_tc, s_tc;
  int         n_checks;
  int         n_fail;

  localparam logic [3:0] GTAB [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110,
    4'b1010, 4'b1011, 4'b1001, 4'b1000
  };

  gray_code_counter #(.WIDTH(4), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up),
    .load(load), .load_gray(load_gray),
    .binary(w_bin), .gray(w_gray), .tc(w_tc)
  );

  gray_code_counter #(.WIDTH(4), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up),
    .load(load), .load_gray(load_gray),
    .binary(s_bin), .gray(s_gray), .tc(s_tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; up = 1'b1;
    load = 1'b0; load_gray = '0;
    #2;
    n_checks++;
    if ({w_bin, w_gray, w_tc} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_async got %b/%b/%b want 0000/0000/0",
               w_bin, w_gray, w_tc);
    end
    step();
    n_checks++;
    if ({s_bin, s_gray, s_tc} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_hold got %b/%b/%b want 0000/0000/0",
               s_bin, s_gray, s_tc);
    end
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_up_count();
    logic [3:0] prev;
    logic [3:0] eb;
    prev = w_gray;
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      eb = 4'(i);
      n_checks++;
      if ({w_bin, w_gray, w_tc} !== {eb, GTAB[eb], i == 16}) begin
        n_fail++;
        $display("FAIL up_count[%0d] got %b/%b/%b want %b/%b/%b",
                 i, w_bin, w_gray, w_tc, eb, GTAB[eb], i == 16);
      end
      n_checks++;
      if ($countones(w_gray ^ prev) != 1 ||
          w_gray !== (w_bin ^ (w_bin >> 1))) begin
        n_fail++;
        $display("FAIL up_single_bit[%0d] got %b prev %b bin %b",
                 i, w_gray, prev, w_bin);
      end
      prev = w_gray;
    end
  endtask

  task automatic test_down_wrap();
    up = 1'b0;
    step();
    n_checks++;
    if ({w_bin, w_gray, w_tc} !== {4'b1111, 4'b1000, 1'b1}) begin
      n_fail++;
      $display("FAIL down_wrap got %b/%b/%b want 1111/1000/1",
               w_bin, w_gray, w_tc);
    end
    step();
    n_checks++;
    if ({w_bin, w_gray, w_tc} !== {4'b1110, 4'b1001, 1'b0}) begin
      n_fail++;
      $display("FAIL down_next got %b/%b/%b want 1110/1001/0",
               w_bin, w_gray, w_tc);
    end
  endtask

  task automatic test_load_priority();
    load = 1'b1; load_gray = 4'b0110; en = 1'b1; up = 1'b1;
    step();
    n_checks++;
    if ({w_bin, w_gray, w_tc} !== {4'b0100, 4'b0110, 1'b0}) begin
      n_fail++;
      $display("FAIL load_prio got %b/%b/%b want 0100/0110/0",
               w_bin, w_gray, w_tc);
    end
    load = 1'b0;
    step();
    n_checks++;
    if ({w_bin, w_gray, w_tc} !== {4'b0101, 4'b0111, 1'b0}) begin
      n_fail++;
      $display("FAIL load_then_count got %b/%b/%b want 0101/0111/0",
               w_bin, w_gray, w_tc);
    end
  endtask

  task automatic test_hold();
    en = 1'b0; up = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if ({w_bin, w_gray, w_tc} !== {4'b0101, 4'b0111, 1'b0}) begin
        n_fail++;
        $display("FAIL hold[%0d] got %b/%b/%b want 0101/0111/0",
                 i, w_bin, w_gray, w_tc);
      end
    end
  endtask

  task automatic test_saturate();
    load = 1'b1; load_gray = 4'b1000;
    step();
    n_checks++;
    if ({s_bin, s_gray, s_tc} !== {4'b1111, 4'b1000, 1'b0}) begin
      n_fail++;
      $display("FAIL sat_load got %b/%b/%b want 1111/1000/0",
               s_bin, s_gray, s_tc);
    end
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({s_bin, s_gray, s_tc} !== {4'b1111, 4'b1000, 1'b1}) begin
        n_fail++;
        $display("FAIL sat_max[%0d] got %b/%b/%b want 1111/1000/1",
                 i, s_bin, s_gray, s_tc);
      end
      if (i == 0) begin
        n_checks++;
        if ({w_bin, w_gray, w_tc} !== {4'b0000, 4'b0000, 1'b1}) begin
          n_fail++;
          $display("FAIL wrap_max got %b/%b/%b want 0000/0000/1",
                   w_bin, w_gray, w_tc);
        end
      end
    end
    up = 1'b0;
    step();
    n_checks++;
    if ({s_bin, s_gray, s_tc} !== {4'b1110, 4'b1001, 1'b0}) begin
      n_fail++;
      $display("FAIL sat_turn got %b/%b/%b want 1110/1001/0",
               s_bin, s_gray, s_tc);
    end
    load = 1'b1; load_gray = 4'b0000;
    step();
    load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if ({s_bin, s_gray, s_tc} !== {4'b0000, 4'b0000, 1'b1}) begin
        n_fail++;
        $display("FAIL sat_min[%0d] got %b/%b/%b want 0000/0000/1",
                 i, s_bin, s_gray, s_tc);
      end
    end
  endtask

  task automatic test_async_reset();
    load = 1'b1; load_gray = 4'b1111; en = 1'b1; up = 1'b1;
    step();
    load = 1'b0;
    n_checks++;
    if (w_bin !== 4'b1010) begin
      n_fail++;
      $display("FAIL areset_setup got %b want 1010", w_bin);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({w_bin, w_gray, w_tc} !== 9'b0) begin
      n_fail++;
      $display("FAIL areset_mid got %b/%b/%b want 0000/0000/0",
               w_bin, w_gray, w_tc);
    end
    step();
    n_checks++;
    if ({w_bin, w_gray, w_tc} !== 9'b0) begin
      n_fail++;
      $display("FAIL areset_held got %b/%b/%b want 0000/0000/0",
               w_bin, w_gray, w_tc);
    end
    #3;
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({w_bin, w_gray, w_tc} !== {4'b0001, 4'b0001, 1'b0}) begin
      n_fail++;
      $display("FAIL areset_up got %b/%b/%b want 0001/0001/0",
               w_bin, w_gray, w_tc);
    end
    #3;
    rst_n = 1'b0;
    up = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({w_bin, w_gray, w_tc} !== {4'b1111, 4'b1000, 1'b1}) begin
      n_fail++;
      $display("FAIL areset_down got %b/%b/%b want 1111/1000/1",
               w_bin, w_gray, w_tc);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_up_count();
    test_down_wrap();
    test_load_priority();
    test_hold();
    test_saturate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
